// File: rtl/fifo_wr_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : fifo_arb_pkg
//  Brief    : Shared types and width helpers for the FIFO write-port arbiter.
//  Revision : 1.0 - initial release
// ============================================================================
package fifo_arb_pkg;

    // Arbiter control states: waiting for a request, or owning the FIFO port.
    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_BURST = 1'b1
    } arb_state_e;

    // Default configuration values.
    localparam int c_DEF_NUM_REQ   = 4;
    localparam int c_DEF_DATA_W    = 8;
    localparam int c_DEF_MAX_BURST = 8;

    // Index width for a requester count (never narrower than one bit).
    function automatic int f_id_w(input int num_req);
        return (num_req > 1) ? $clog2(num_req) : 1;
    endfunction

    // Beat counter width: must be able to hold MAX_BURST itself.
    function automatic int f_cnt_w(input int max_burst);
        return (max_burst > 0) ? $clog2(max_burst + 1) : 1;
    endfunction

    // Width helpers for the default configuration.
    localparam int c_DEF_ID_W  = f_id_w(c_DEF_NUM_REQ);
    localparam int c_DEF_CNT_W = f_cnt_w(c_DEF_MAX_BURST);

endpackage
`default_nettype wire

// File: rtl/fifo_wr_arbiter_rr_picker.sv
`default_nettype none
// ============================================================================
//  Module   : rr_picker
//  Brief    : Combinational rotate-priority encoder. Returns the first set
//             request bit scanning i_ptr, i_ptr+1, ... modulo NUM_REQ.
//  Revision : 1.0 - initial release
// ============================================================================
module rr_picker
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ = c_DEF_NUM_REQ,
    parameter int ID_W    = f_id_w(NUM_REQ)
)(
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [ID_W-1:0]    i_ptr,
    output logic               o_any,
    output logic [ID_W-1:0]    o_winner
);

    logic [ID_W:0]   w_sum;
    logic [ID_W-1:0] w_idx;

    // Scan from the farthest offset down to offset 0 so the closest set bit
    // to the pointer is the last one written and therefore wins.
    always_comb begin
        o_any    = 1'b0;
        o_winner = '0;
        w_sum    = '0;
        w_idx    = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            w_sum = {1'b0, i_ptr} + (ID_W + 1)'(i);
            if (w_sum >= (ID_W + 1)'(NUM_REQ)) begin
                w_sum = w_sum - (ID_W + 1)'(NUM_REQ);
            end
            w_idx = w_sum[ID_W-1:0];
            if (i_req[w_idx]) begin
                o_any    = 1'b1;
                o_winner = w_idx;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/fifo_wr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : fifo_wr_arbiter
//  Brief    : Packet-locked round-robin arbiter sharing one FIFO write port
//             among NUM_REQ requesters, with burst-length limiting and
//             backpressure steered to the current owner only.
//  Revision : 1.0 - initial release
// ============================================================================
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ   = c_DEF_NUM_REQ,
    parameter int DATA_W    = c_DEF_DATA_W,
    parameter int MAX_BURST = c_DEF_MAX_BURST
)(
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    input  logic [NUM_REQ-1:0]        req_last,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic                      fifo_wr_en,
    output logic [DATA_W-1:0]         fifo_wr_data,
    input  logic                      fifo_full,
    output logic                      grant_active,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic                      burst_trunc
);

    localparam int c_ID_W  = f_id_w(NUM_REQ);
    localparam int c_CNT_W = f_cnt_w(MAX_BURST);

    arb_state_e          r_state;
    arb_state_e          w_state_nxt;
    logic [c_ID_W-1:0]   r_rr_ptr;
    logic [c_ID_W-1:0]   w_rr_ptr_nxt;
    logic [c_ID_W-1:0]   r_grant_id;
    logic [c_ID_W-1:0]   w_grant_id_nxt;
    logic [c_CNT_W-1:0]  r_beat_cnt;
    logic [c_CNT_W-1:0]  w_beat_cnt_nxt;
    logic                r_grant_active;
    logic                w_grant_active_nxt;
    logic                r_burst_trunc;
    logic                w_burst_trunc_nxt;

    logic                w_any_req;
    logic [c_ID_W-1:0]   w_winner;
    logic                w_in_burst;
    logic                w_sel_valid;
    logic                w_sel_last;
    logic [DATA_W-1:0]   w_sel_data;
    logic                w_xfer;
    logic                w_at_limit;
    logic                w_end;
    logic [c_ID_W-1:0]   w_after_owner;

    rr_picker #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (c_ID_W)
    ) u_rr_picker (
        .i_req    (req_valid),
        .i_ptr    (r_rr_ptr),
        .o_any    (w_any_req),
        .o_winner (w_winner)
    );

    // Select the owner's beat and decide whether it transfers this cycle.
    always_comb begin
        w_in_burst    = (r_state == ARB_BURST);
        w_sel_valid   = req_valid[r_grant_id];
        w_sel_last    = req_last[r_grant_id];
        w_sel_data    = req_data[int'(r_grant_id)*DATA_W +: DATA_W];
        w_xfer        = w_in_burst && w_sel_valid && !fifo_full;
        w_at_limit    = (r_beat_cnt == c_CNT_W'(MAX_BURST - 1));
        w_end         = w_xfer && (w_sel_last || w_at_limit);
        w_after_owner = (r_grant_id == c_ID_W'(NUM_REQ - 1)) ? '0
                                                              : r_grant_id + 1'b1;
    end

    // Beat handshake and FIFO write path; only the owner ever sees ready.
    always_comb begin
        req_ready    = '0;
        if (w_in_burst && !fifo_full) begin
            req_ready[r_grant_id] = 1'b1;
        end
        fifo_wr_en   = w_xfer;
        fifo_wr_data = w_xfer ? w_sel_data : '0;
    end

    // Next-state logic: grant in IDLE, count beats and release in BURST.
    always_comb begin
        w_state_nxt        = r_state;
        w_rr_ptr_nxt       = r_rr_ptr;
        w_grant_id_nxt     = r_grant_id;
        w_beat_cnt_nxt     = r_beat_cnt;
        w_grant_active_nxt = r_grant_active;
        w_burst_trunc_nxt  = 1'b0;
        case (r_state)
            ARB_IDLE: begin
                if (w_any_req) begin
                    w_state_nxt        = ARB_BURST;
                    w_grant_id_nxt     = w_winner;
                    w_grant_active_nxt = 1'b1;
                    w_beat_cnt_nxt     = '0;
                end
            end
            ARB_BURST: begin
                if (w_xfer) begin
                    w_beat_cnt_nxt = r_beat_cnt + 1'b1;
                end
                if (w_end) begin
                    w_state_nxt        = ARB_IDLE;
                    w_grant_active_nxt = 1'b0;
                    w_rr_ptr_nxt       = w_after_owner;
                    // A limit hit that coincides with req_last is a normal end.
                    w_burst_trunc_nxt  = !w_sel_last;
                end
            end
            default: begin
                w_state_nxt        = ARB_IDLE;
                w_grant_active_nxt = 1'b0;
            end
        endcase
    end

    // State register with synchronous reset; a reset abandons any burst.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= ARB_IDLE;
            r_rr_ptr       <= '0;
            r_grant_id     <= '0;
            r_beat_cnt     <= '0;
            r_grant_active <= 1'b0;
            r_burst_trunc  <= 1'b0;
        end else begin
            r_state        <= w_state_nxt;
            r_rr_ptr       <= w_rr_ptr_nxt;
            r_grant_id     <= w_grant_id_nxt;
            r_beat_cnt     <= w_beat_cnt_nxt;
            r_grant_active <= w_grant_active_nxt;
            r_burst_trunc  <= w_burst_trunc_nxt;
        end
    end

    // Registered status outputs.
    always_comb begin
        grant_active = r_grant_active;
        grant_id     = r_grant_id;
        burst_trunc  = r_burst_trunc;
    end

endmodule
`default_nettype wire

// File: tb/tb_fifo_wr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fifo_wr_arbiter
//  Brief    : Self-checking bench for fifo_wr_arbiter (4 requesters, 8-bit
//             data, MAX_BURST=8) using per-cycle vectors plus a hand-written
//             reset-mid-burst sequence.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_fifo_wr_arbiter;

    localparam int c_N   = 4;
    localparam int c_DW  = 8;
    localparam int c_MAX = 8;

    logic                  clk;
    logic                  rst;
    logic [c_N-1:0]        req_valid;
    logic [c_N*c_DW-1:0]   req_data;
    logic [c_N-1:0]        req_last;
    logic [c_N-1:0]        req_ready;
    logic                  fifo_wr_en;
    logic [c_DW-1:0]       fifo_wr_data;
    logic                  fifo_full;
    logic                  grant_active;
    logic [1:0]            grant_id;
    logic                  burst_trunc;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic        rst;
        logic [3:0]  v;
        logic [3:0]  l;
        logic        f;
        logic [31:0] d;
        logic [3:0]  e_rdy;
        logic        e_wen;
        logic [7:0]  e_wd;
        logic        e_ga;
        logic [1:0]  e_gid;
        logic        e_tr;
    } vec_t;

    vec_t vec_q[$];

    fifo_wr_arbiter #(
        .NUM_REQ   (c_N),
        .DATA_W    (c_DW),
        .MAX_BURST (c_MAX)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_data     (req_data),
        .req_last     (req_last),
        .req_ready    (req_ready),
        .fifo_wr_en   (fifo_wr_en),
        .fifo_wr_data (fifo_wr_data),
        .fifo_full    (fifo_full),
        .grant_active (grant_active),
        .grant_id     (grant_id),
        .burst_trunc  (burst_trunc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int row,
                       input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s row %0d: got %0h expected %0h", name, row, act, exp);
        end
    endtask

    task automatic add(input logic r, input logic [3:0] v, input logic [3:0] l,
                       input logic f, input logic [31:0] d,
                       input logic [3:0] erdy, input logic ewen, input logic [7:0] ewd,
                       input logic ega, input logic [1:0] egid, input logic etr);
        vec_t t;
        t.rst = r; t.v = v; t.l = l; t.f = f; t.d = d;
        t.e_rdy = erdy; t.e_wen = ewen; t.e_wd = ewd;
        t.e_ga = ega; t.e_gid = egid; t.e_tr = etr;
        vec_q.push_back(t);
    endtask

    initial begin
        bit got;

        // ---- vector table: one row per cycle, outputs expected in that cycle
        // reset state
        add(0, 4'h0, 4'h0, 0, 32'h0,           4'h0, 0, 8'h00, 0, 2'd0, 0);
        // single 3-beat packet from req1
        add(0, 4'h2, 4'h0, 0, 32'h0000_A100,   4'h0, 0, 8'h00, 0, 2'd0, 0);
        add(0, 4'h2, 4'h0, 0, 32'h0000_A100,   4'h2, 1, 8'hA1, 1, 2'd1, 0);
        add(0, 4'h2, 4'h0, 0, 32'h0000_A200,   4'h2, 1, 8'hA2, 1, 2'd1, 0);
        add(0, 4'h2, 4'h2, 0, 32'h0000_A300,   4'h2, 1, 8'hA3, 1, 2'd1, 0);
        add(0, 4'h0, 4'h0, 0, 32'h0,           4'h0, 0, 8'h00, 0, 2'd1, 0);
        // round robin between req0 and req2, 1-beat packets (ptr starts at 2)
        add(0, 4'h5, 4'h5, 0, 32'h0020_0010,   4'h0, 0, 8'h00, 0, 2'd1, 0);
        add(0, 4'h5, 4'h5, 0, 32'h0020_0010,   4'h4, 1, 8'h20, 1, 2'd2, 0);
        add(0, 4'h5, 4'h5, 0, 32'h0020_0010,   4'h0, 0, 8'h00, 0, 2'd2, 0);
        add(0, 4'h5, 4'h5, 0, 32'h0020_0010,   4'h1, 1, 8'h10, 1, 2'd0, 0);
        add(0, 4'h5, 4'h5, 0, 32'h0020_0010,   4'h0, 0, 8'h00, 0, 2'd0, 0);
        add(0, 4'h5, 4'h5, 0, 32'h0020_0010,   4'h4, 1, 8'h20, 1, 2'd2, 0);
        add(0, 4'h5, 4'h5, 0, 32'h0020_0010,   4'h0, 0, 8'h00, 0, 2'd2, 0);
        add(0, 4'h5, 4'h5, 0, 32'h0020_0010,   4'h1, 1, 8'h10, 1, 2'd0, 0);
        add(0, 4'h0, 4'h0, 0, 32'h0,           4'h0, 0, 8'h00, 0, 2'd0, 0);
        // backpressure on req3's 4-beat burst
        add(0, 4'h8, 4'h0, 0, 32'hB000_0000,   4'h0, 0, 8'h00, 0, 2'd0, 0);
        add(0, 4'h8, 4'h0, 0, 32'hB000_0000,   4'h8, 1, 8'hB0, 1, 2'd3, 0);
        add(0, 4'h8, 4'h0, 1, 32'hB100_0000,   4'h0, 0, 8'h00, 1, 2'd3, 0);
        add(0, 4'h8, 4'h0, 1, 32'hB100_0000,   4'h0, 0, 8'h00, 1, 2'd3, 0);
        add(0, 4'h8, 4'h0, 1, 32'hB100_0000,   4'h0, 0, 8'h00, 1, 2'd3, 0);
        add(0, 4'h8, 4'h0, 0, 32'hB100_0000,   4'h8, 1, 8'hB1, 1, 2'd3, 0);
        add(0, 4'h8, 4'h0, 0, 32'hB200_0000,   4'h8, 1, 8'hB2, 1, 2'd3, 0);
        add(0, 4'h8, 4'h8, 0, 32'hB300_0000,   4'h8, 1, 8'hB3, 1, 2'd3, 0);
        add(0, 4'h0, 4'h0, 0, 32'h0,           4'h0, 0, 8'h00, 0, 2'd3, 0);
        // move ptr to 3 with a req2 packet, then all four contend: 3,0,1,2
        add(0, 4'h4, 4'h4, 0, 32'h00C2_0000,   4'h0, 0, 8'h00, 0, 2'd3, 0);
        add(0, 4'hF, 4'hF, 0, 32'hD3D2_D1D0,   4'h4, 1, 8'hD2, 1, 2'd2, 0);
        add(0, 4'hF, 4'hF, 0, 32'hD3D2_D1D0,   4'h0, 0, 8'h00, 0, 2'd2, 0);
        add(0, 4'hF, 4'hF, 0, 32'hD3D2_D1D0,   4'h8, 1, 8'hD3, 1, 2'd3, 0);
        add(0, 4'hF, 4'hF, 0, 32'hD3D2_D1D0,   4'h0, 0, 8'h00, 0, 2'd3, 0);
        add(0, 4'hF, 4'hF, 0, 32'hD3D2_D1D0,   4'h1, 1, 8'hD0, 1, 2'd0, 0);
        add(0, 4'hF, 4'hF, 0, 32'hD3D2_D1D0,   4'h0, 0, 8'h00, 0, 2'd0, 0);
        add(0, 4'hF, 4'hF, 0, 32'hD3D2_D1D0,   4'h2, 1, 8'hD1, 1, 2'd1, 0);
        add(0, 4'hF, 4'hF, 0, 32'hD3D2_D1D0,   4'h0, 0, 8'h00, 0, 2'd1, 0);
        add(0, 4'hF, 4'hF, 0, 32'hD3D2_D1D0,   4'h4, 1, 8'hD2, 1, 2'd2, 0);
        add(0, 4'h0, 4'h0, 0, 32'h0,           4'h0, 0, 8'h00, 0, 2'd2, 0);
        // truncation: req1 streams 10 beats with no last, valid gap after beat 4
        add(0, 4'h2, 4'h0, 0, 32'h0000_E000,   4'h0, 0, 8'h00, 0, 2'd2, 0);
        for (int k = 0; k < 8; k++) begin
            add(0, 4'h2, 4'h0, 0, 32'(8'(8'hE0 + k)) << 8,
                4'h2, 1, 8'(8'hE0 + k), 1, 2'd1, 0);
            if (k == 3) begin
                add(0, 4'h0, 4'h0, 0, 32'h0, 4'h2, 0, 8'h00, 1, 2'd1, 0);
            end
        end
        add(0, 4'h2, 4'h0, 0, 32'h0000_E800,   4'h0, 0, 8'h00, 0, 2'd1, 1);
        add(0, 4'h2, 4'h0, 0, 32'h0000_E800,   4'h2, 1, 8'hE8, 1, 2'd1, 0);
        add(0, 4'h2, 4'h2, 0, 32'h0000_E900,   4'h2, 1, 8'hE9, 1, 2'd1, 0);
        add(0, 4'h0, 4'h0, 0, 32'h0,           4'h0, 0, 8'h00, 0, 2'd1, 0);
        // last and limit on the same beat: normal end, no truncation pulse
        add(0, 4'h2, 4'h0, 0, 32'h0000_F000,   4'h0, 0, 8'h00, 0, 2'd1, 0);
        for (int k = 0; k < 8; k++) begin
            add(0, 4'h2, (k == 7) ? 4'h2 : 4'h0, 0, 32'(8'(8'hF0 + k)) << 8,
                4'h2, 1, 8'(8'hF0 + k), 1, 2'd1, 0);
        end
        add(0, 4'h0, 4'h0, 0, 32'h0,           4'h0, 0, 8'h00, 0, 2'd1, 0);

        // ---- reset
        rst = 1'b1; req_valid = '0; req_last = '0; req_data = '0; fifo_full = 1'b0;
        repeat (2) @(posedge clk);

        // ---- apply table
        foreach (vec_q[i]) begin
            @(negedge clk);
            rst       = vec_q[i].rst;
            req_valid = vec_q[i].v;
            req_last  = vec_q[i].l;
            fifo_full = vec_q[i].f;
            req_data  = vec_q[i].d;
            #1;
            chk("req_ready",    i, 32'(req_ready),    32'(vec_q[i].e_rdy));
            chk("fifo_wr_en",   i, 32'(fifo_wr_en),   32'(vec_q[i].e_wen));
            chk("fifo_wr_data", i, 32'(fifo_wr_data), 32'(vec_q[i].e_wd));
            chk("grant_active", i, 32'(grant_active), 32'(vec_q[i].e_ga));
            chk("grant_id",     i, 32'(grant_id),     32'(vec_q[i].e_gid));
            chk("burst_trunc",  i, 32'(burst_trunc),  32'(vec_q[i].e_tr));
        end

        // ---- reset mid-burst (rr_ptr is 2 here, so a reset-cleared pointer
        //      is what makes req0 win the following contention)
        @(negedge clk);
        req_valid = 4'h1; req_last = 4'h0; req_data = 32'h0000_0055;
        got = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            #1;
            if (grant_active) begin
                got = 1'b1;
                break;
            end
        end
        chk("rst_seq grant seen", 100, 32'(got), 32'd1);
        chk("rst_seq beat1 wen", 101, 32'(fifo_wr_en), 32'd1);
        @(negedge clk);
        rst = 1'b1;                       // beat 2 of the burst
        @(negedge clk);
        rst = 1'b0; req_valid = 4'h5; req_last = 4'h5; req_data = 32'h0066_0077;
        #1;
        chk("rst_seq grant_active", 102, 32'(grant_active), 32'd0);
        chk("rst_seq req_ready",    103, 32'(req_ready),    32'd0);
        chk("rst_seq fifo_wr_en",   104, 32'(fifo_wr_en),   32'd0);
        chk("rst_seq grant_id",     105, 32'(grant_id),     32'd0);
        chk("rst_seq burst_trunc",  106, 32'(burst_trunc),  32'd0);
        @(negedge clk);
        #1;
        chk("rst_seq regrant active", 107, 32'(grant_active), 32'd1);
        chk("rst_seq regrant id",     108, 32'(grant_id),     32'd0);
        chk("rst_seq regrant data",   109, 32'(fifo_wr_data), 32'h77);
        @(negedge clk);
        req_valid = '0; req_last = '0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
